ex_mem_pipe_reg: RTL and testbench
==================================

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of one datapath word.
REQ-002 Parameter NUM_DATA, default 4, number of datapath words carried: ALU add result, ALU result, read data 2, mux2 result.
REQ-003 Parameter CTRL_W, default 5, control bits carried: MemWrite, MemRead, Branch, MemtoReg, RegWrite, LSB first.
REQ-004 Parameter STALL_CNT_W, default 16, width of the stall counter.
REQ-005 Clk_in_EXMEM  in  1  sole clock; all state updates on its rising edge.
REQ-006 Rst_n_in_EXMEM  in  1  asynchronous active-low reset.
REQ-007 Valid_in_EXMEM  in  1  upstream payload valid.
REQ-008 Ready_out_EXMEM  out  1  block can accept payload this cycle.
REQ-009 Ctrl_in_EXMEM  in  CTRL_W  control bits.
REQ-010 Zero_in_EXMEM  in  1  ALU zero flag.
REQ-011 Data_in_EXMEM  in  NUM_DATA*DATA_W  packed words, word 0 in LSBs.
REQ-012 Flush_in_EXMEM  in  1  synchronous bubble insertion request.
REQ-013 Valid_out_EXMEM  out  1  output payload valid.
REQ-014 Ready_in_EXMEM  in  1  downstream accepts payload.
REQ-015 Ctrl_out_EXMEM  out  CTRL_W; Zero_out_EXMEM  out  1; Data_out_EXMEM  out  NUM_DATA*DATA_W: registered payload.
REQ-016 StallCnt_out_EXMEM  out  STALL_CNT_W  stall cycle count; present only per REQ-034.

Function
REQ-017 Input fire = Valid_in & Ready_out; output fire = Valid_out & Ready_in.
REQ-018 Block SHALL be a two-entry elastic stage: main register drives outputs, skid register absorbs one payload under back-pressure.
REQ-019 States: EMPTY (no entry), ONE (main full), TWO (main and skid full).
REQ-020 Valid_out = (state != EMPTY); Ready_out = (state != TWO), decoded from registered state only, no combinational path from Ready_in.
REQ-021 EMPTY: input fire -> load main, go ONE; else stay.
REQ-022 ONE: input and output fire -> load main, stay ONE; input fire only -> load skid, go TWO; output fire only -> go EMPTY; neither -> hold.
REQ-023 TWO: Ready_in=1 -> main <= skid, go ONE; Ready_in=0 -> hold; no input accepted in TWO.
REQ-024 Latency input fire to Valid_out = 1 cycle when EMPTY; sustained throughput 1 payload/cycle with Ready_in held 1.
REQ-025 Payload order SHALL be preserved; no payload duplicated or dropped except by flush.
REQ-026 Payload on outputs SHALL be stable while Valid_out=1 and Ready_in=0.
REQ-027 Flush_in=1 has priority over all transitions: next state EMPTY, main and skid Ctrl cleared to 0, Zero cleared, Data registers hold; any same-cycle input fire is discarded.
REQ-028 Ctrl_out SHALL read 0 whenever Valid_out=0 (bubble never writes memory or register file).
REQ-029 Flush while TWO SHALL discard both entries.

Reset
REQ-030 Rst_n_in low SHALL asynchronously force state EMPTY, all payload registers 0, Valid_out 0, Ready_out 1.
REQ-031 Reset mid-transfer SHALL discard all held payloads; first input fire after release behaves as from EMPTY.
REQ-032 Reset release SHALL be sampled on rising edge; no state change on the release edge other than normal EMPTY behaviour.

Configuration
REQ-033 Macro EXMEM_STALL_CNT_EN selects the stall counter.
REQ-034 Defined: StallCnt_out present; increments each cycle Valid_out=1 and Ready_in=0; saturates at all-ones; cleared only by reset, not by flush.
REQ-035 Not defined: StallCnt_out port and counter logic absent; all other behaviour identical.

Verification
REQ-036 Reset then Valid_in=1, Ctrl=5'b10001, Data word0=32'h0000_00A5, Ready_in=1 -> next cycle Valid_out=1, Ctrl_out=5'b10001, word0=32'hA5.
REQ-037 Stream 8 payloads 1..8 with Ready_in=1 -> outputs 1..8 on consecutive cycles, Ready_out constantly 1.
REQ-038 Ready_in=0 while sending 3 payloads -> Ready_out falls after 2nd accepted, 3rd held upstream; Ready_in=1 -> outputs 1,2,3 in order, none lost.
REQ-039 State TWO with payloads A,B, assert Flush_in one cycle -> next cycle Valid_out=0, Ctrl_out=0, Ready_out=1; A,B never appear.
REQ-040 With EXMEM_STALL_CNT_EN, STALL_CNT_W=4, hold Valid_out=1, Ready_in=0 for 20 cycles -> StallCnt_out=4'hF; flush -> stays 4'hF; reset -> 0.
REQ-041 Assert Rst_n_in low asynchronously mid-cycle in state ONE -> Valid_out=0 and Ctrl_out=0 immediately, before next clock edge.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM two-entry elastic pipeline register; EXMEM_STALL_CNT_EN adds a stall counter
module ex_mem_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int NUM_DATA    = 4,
  parameter int CTRL_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                       Clk_in_EXMEM,
  input  logic                       Rst_n_in_EXMEM,
  input  logic                       Valid_in_EXMEM,
  output logic                       Ready_out_EXMEM,
  input  logic [CTRL_W-1:0]          Ctrl_in_EXMEM,
  input  logic                       Zero_in_EXMEM,
  input  logic [NUM_DATA*DATA_W-1:0] Data_in_EXMEM,
  input  logic                       Flush_in_EXMEM,
  output logic                       Valid_out_EXMEM,
  input  logic                       Ready_in_EXMEM,
  output logic [CTRL_W-1:0]          Ctrl_out_EXMEM,
  output logic                       Zero_out_EXMEM,
  output logic [NUM_DATA*DATA_W-1:0] Data_out_EXMEM
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]     StallCnt_out_EXMEM
`endif
);

  localparam int PAY_W = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic                main_zero_q, main_zero_d;
  logic [PAY_W-1:0]    main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                skid_zero_q, skid_zero_d;
  logic [PAY_W-1:0]    skid_data_q, skid_data_d;
  logic                in_fire;
  logic                out_fire;

  // Handshake outputs come from registered state only, so Ready_in never reaches Ready_out.
  assign Valid_out_EXMEM = (state_q != ST_EMPTY);
  assign Ready_out_EXMEM = (state_q != ST_TWO);
  assign in_fire         = Valid_in_EXMEM & Ready_out_EXMEM;
  assign out_fire        = Valid_out_EXMEM & Ready_in_EXMEM;

  assign Ctrl_out_EXMEM  = main_ctrl_q;
  assign Zero_out_EXMEM  = main_zero_q;
  assign Data_out_EXMEM  = main_data_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_zero_d = main_zero_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_zero_d = skid_zero_q;
    skid_data_d = skid_data_q;

    if (Flush_in_EXMEM) begin
      // Bubble: control and flag are cleared so nothing downstream acts; data words are don't-care.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_zero_d = 1'b0;
      skid_ctrl_d = '0;
      skid_zero_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = Ctrl_in_EXMEM;
            main_zero_d = Zero_in_EXMEM;
            main_data_d = Data_in_EXMEM;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = Ctrl_in_EXMEM;
            main_zero_d = Zero_in_EXMEM;
            main_data_d = Data_in_EXMEM;
          end else if (in_fire) begin
            skid_ctrl_d = Ctrl_in_EXMEM;
            skid_zero_d = Zero_in_EXMEM;
            skid_data_d = Data_in_EXMEM;
            state_d     = ST_TWO;
          end else if (out_fire) begin
            // Draining to empty clears control so an idle stage never presents live write enables.
            main_ctrl_d = '0;
            main_zero_d = 1'b0;
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (Ready_in_EXMEM) begin
            main_ctrl_d = skid_ctrl_q;
            main_zero_d = skid_zero_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          main_ctrl_d = '0;
          main_zero_d = 1'b0;
          state_d     = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_in_EXMEM or negedge Rst_n_in_EXMEM) begin
    if (!Rst_n_in_EXMEM) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_zero_q <= 1'b0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_zero_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_zero_q <= main_zero_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_zero_q <= skid_zero_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef EXMEM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the output is held by downstream; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Valid_out_EXMEM && !Ready_in_EXMEM && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_in_EXMEM or negedge Rst_n_in_EXMEM) begin
    if (!Rst_n_in_EXMEM) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt_out_EXMEM = stall_cnt_q;
`else
  if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
    $error("STALL_CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - self-checking bench for ex_mem_pipe_reg
module tb_ex_mem_pipe_reg;

  localparam int DW = 32;
  localparam int ND = 4;
  localparam int CW = 5;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vin, rdy_out, fl, vout, rin, zin, zout;
  logic [CW-1:0]     cin, cout;
  logic [ND*DW-1:0]  din, dout;
`ifdef EXMEM_STALL_CNT_EN
  logic [SW-1:0]     stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .Clk_in_EXMEM      (clk),
    .Rst_n_in_EXMEM    (rst_n),
    .Valid_in_EXMEM    (vin),
    .Ready_out_EXMEM   (rdy_out),
    .Ctrl_in_EXMEM     (cin),
    .Zero_in_EXMEM     (zin),
    .Data_in_EXMEM     (din),
    .Flush_in_EXMEM    (fl),
    .Valid_out_EXMEM   (vout),
    .Ready_in_EXMEM    (rin),
    .Ctrl_out_EXMEM    (cout),
    .Zero_out_EXMEM    (zout),
    .Data_out_EXMEM    (dout)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .StallCnt_out_EXMEM(stall_cnt)
`endif
  );

  typedef struct {
    logic        vin, rin, fl;
    logic [4:0]  ctrl;
    logic        z;
    logic [31:0] d;
    logic        ev, er;
    logic [4:0]  ectrl;
    logic        ez;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [127:0] mkdata(input logic [31:0] d);
    return {~d, d ^ 32'h5a5a_5a5a, d + 32'd1, d};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [4:0] c,
                       input logic z, input logic [31:0] d);
    vin = v; rin = r; fl = f; cin = c; zin = z; din = mkdata(d);
  endtask

  logic [31:0] got[$];
  int          sent;
  logic        in_f;

  initial begin
    tbl[0]  = '{1,1,0,5'h11,1,32'hA5, 1,1,5'h11,1,32'hA5};
    tbl[1]  = '{1,1,0,5'h02,0,32'h01, 1,1,5'h02,0,32'h01};
    tbl[2]  = '{1,0,0,5'h03,0,32'h02, 1,0,5'h02,0,32'h01};
    tbl[3]  = '{1,0,0,5'h04,0,32'h03, 1,0,5'h02,0,32'h01};
    tbl[4]  = '{1,1,0,5'h04,0,32'h03, 1,1,5'h03,0,32'h02};
    tbl[5]  = '{1,1,0,5'h04,0,32'h03, 1,1,5'h04,0,32'h03};
    tbl[6]  = '{0,1,0,5'h00,0,32'h00, 0,1,5'h00,0,32'h03};
    tbl[7]  = '{0,0,0,5'h00,0,32'h00, 0,1,5'h00,0,32'h03};
    tbl[8]  = '{1,0,0,5'h1F,1,32'h10, 1,1,5'h1F,1,32'h10};
    tbl[9]  = '{1,0,0,5'h06,0,32'h11, 1,0,5'h1F,1,32'h10};
    tbl[10] = '{0,0,1,5'h00,0,32'h00, 0,1,5'h00,0,32'h10};
    tbl[11] = '{1,1,1,5'h07,1,32'h20, 0,1,5'h00,0,32'h10};
    tbl[12] = '{1,1,0,5'h08,0,32'h21, 1,1,5'h08,0,32'h21};
    tbl[13] = '{0,1,0,5'h00,0,32'h00, 0,1,5'h00,0,32'h21};
    tbl[14] = '{1,0,0,5'h09,1,32'h30, 1,1,5'h09,1,32'h30};
    tbl[15] = '{0,0,1,5'h00,0,32'h00, 0,1,5'h00,0,32'h30};

    rst_n = 1'b0;
    drive(0, 0, 0, 5'h00, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(vout), 128'd0);
    chk("rst_ready", 128'(rdy_out), 128'd1);
    chk("rst_ctrl", 128'(cout), 128'd0);
    chk("rst_zero", 128'(zout), 128'd0);
    chk("rst_data", dout, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", 128'(vout), 128'd0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].vin, tbl[i].rin, tbl[i].fl, tbl[i].ctrl, tbl[i].z, tbl[i].d);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 128'(vout), 128'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 128'(rdy_out), 128'(tbl[i].er));
      chk($sformatf("vec%0d_ctrl", i), 128'(cout), 128'(tbl[i].ectrl));
      chk($sformatf("vec%0d_zero", i), 128'(zout), 128'(tbl[i].ez));
      chk($sformatf("vec%0d_data", i), dout, mkdata(tbl[i].ed));
    end

    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 5'(i), 0, 32'(i));
      chk($sformatf("stream%0d_ready", i), 128'(rdy_out), 128'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_valid", i), 128'(vout), 128'd1);
      chk($sformatf("stream%0d_data", i), dout, mkdata(32'(i)));
    end
    drive(0, 1, 0, 5'h00, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("stream_drain_valid", 128'(vout), 128'd0);

    sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive(sent < 3, cyc >= 3, 0, 5'h01, 0, 32'(sent + 1));
      if (cyc == 2) begin
        chk("bp_ready_low", 128'(rdy_out), 128'd0);
        chk("bp_accepted", 128'(sent), 128'd2);
        chk("bp_stable", 128'(dout[31:0]), 128'd1);
      end
      in_f = vin && rdy_out;
      if (vout && rin) got.push_back(dout[31:0]);
      @(posedge clk);
      #1;
      if (in_f) sent++;
    end
    chk("bp_count", 128'(got.size()), 128'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk($sformatf("bp_order%0d", i), 128'(got[i]), 128'(i + 1));
    end

    drive(1, 0, 0, 5'h15, 1, 32'h77);
    @(posedge clk);
    #1;
    chk("ar_pre_valid", 128'(vout), 128'd1);
    drive(0, 0, 0, 5'h00, 0, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(vout), 128'd0);
    chk("ar_ctrl", 128'(cout), 128'd0);
    chk("ar_ready", 128'(rdy_out), 128'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_release_valid", 128'(vout), 128'd0);
    drive(1, 1, 0, 5'h01, 0, 32'h88);
    @(posedge clk);
    #1;
    chk("ar_first_valid", 128'(vout), 128'd1);
    chk("ar_first_data", dout, mkdata(32'h88));
    drive(0, 1, 0, 5'h00, 0, 32'h0);
    @(posedge clk);
    #1;

`ifdef EXMEM_STALL_CNT_EN
    drive(1, 0, 0, 5'h01, 0, 32'h99);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 5'h00, 0, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_sat", 128'(stall_cnt), 128'hF);
    fl = 1'b1;
    @(posedge clk);
    #1;
    fl = 1'b0;
    chk("stall_flush_keep", 128'(stall_cnt), 128'hF);
    chk("stall_flush_valid", 128'(vout), 128'd0);
    rst_n = 1'b0;
    #1;
    chk("stall_reset", 128'(stall_cnt), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
